// File: rtl/multichan_peak_tracker.sv
// multichan_peak_tracker
// Tracks the running maximum of unsigned ADC samples per channel over a
// window of WINDOW accepted samples, then scans the channels for the
// overall peak (ties -> lowest channel) and reports value and channel.
// Optional feature macro: PEAK_HYST_EN -- the reported channel only moves
// away from the previous result channel when the new winner exceeds that
// channel's current-window maximum by more than HYST LSBs.
module multichan_peak_tracker #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int WINDOW   = 1024,
  parameter int HYST     = 16,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [CW-1:0]    sample_ch,
  input  logic [WIDTH-1:0] sample_data,
  output logic [WIDTH-1:0] result_value,
  output logic [CW-1:0]    result_ch,
  output logic             result_valid,
  output logic             ch_err
);

  localparam int              CNTW     = $clog2(WINDOW + 1);
  localparam logic [CNTW-1:0] WIN_L    = CNTW'(WINDOW);
  localparam logic [CW-1:0]   LAST_IDX = CW'(CHANNELS - 1);

  // Reject parameter sets outside the supported range at elaboration.
  generate
    if (CHANNELS < 2 || CHANNELS > 16 || WINDOW < 1 || HYST < 0) begin : g_param_check
      $error("multichan_peak_tracker: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ch_max_q [CHANNELS];
  logic [WIDTH-1:0] ch_max_d [CHANNELS];
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]    scan_idx_q, scan_idx_d;
  logic [WIDTH-1:0] best_val_q, best_val_d;
  logic [CW-1:0]    best_ch_q, best_ch_d;
  logic [WIDTH-1:0] result_value_q, result_value_d;
  logic [CW-1:0]    result_ch_q, result_ch_d;
  logic             result_valid_q, result_valid_d;
  logic             ch_err_q, ch_err_d;

  logic             accept_s;
  logic             ch_oob_s;
  logic [CNTW-1:0]  cnt_inc_s;
  logic [WIDTH-1:0] scan_val_s;

`ifdef PEAK_HYST_EN
  // Set until the first report after reset or clear: that report is unconditional.
  logic             first_q, first_d;
  logic [WIDTH-1:0] prev_val_s;
  logic             hyst_win_s;
`endif

  assign sample_ready = (state_q == ST_ACCUM);
  assign accept_s     = sample_valid && sample_ready;
  assign ch_oob_s     = ({1'b0, sample_ch} >= (CW + 1)'(CHANNELS));
  assign cnt_inc_s    = cnt_q + CNTW'(1);

  assign result_value = result_value_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign ch_err       = ch_err_q;

  // Select the channel maximum currently visited by the scan (AND-OR mux, no out-of-range index).
  always_comb begin
    scan_val_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      scan_val_s = scan_val_s | ((CW'(c) == scan_idx_q) ? ch_max_q[c] : {WIDTH{1'b0}});
    end
  end

`ifdef PEAK_HYST_EN
  // Current-window maximum of the previously reported channel and the hysteresis qualification.
  always_comb begin
    prev_val_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prev_val_s = prev_val_s | ((CW'(c) == result_ch_q) ? ch_max_q[c] : {WIDTH{1'b0}});
    end
    hyst_win_s = ({1'b0, best_val_q} > ({1'b0, prev_val_s} + (WIDTH + 1)'(HYST)));
  end
`endif

  // Next-state and datapath logic: accumulate, scan for the peak, report; clear overrides all.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    scan_idx_d     = scan_idx_q;
    best_val_d     = best_val_q;
    best_ch_d      = best_ch_q;
    result_value_d = result_value_q;
    result_ch_d    = result_ch_q;
    result_valid_d = 1'b0;
    ch_err_d       = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_max_d[c] = ch_max_q[c];
    end
`ifdef PEAK_HYST_EN
    first_d = first_q;
`endif

    if (clear) begin
      // Abort the window; the accepted sample (if any) and its error are dropped.
      state_d    = ST_ACCUM;
      cnt_d      = '0;
      scan_idx_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_max_d[c] = '0;
      end
`ifdef PEAK_HYST_EN
      first_d = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s) begin
            cnt_d    = cnt_inc_s;
            ch_err_d = ch_oob_s;
            for (int c = 0; c < CHANNELS; c++) begin
              ch_max_d[c] = (!ch_oob_s && (CW'(c) == sample_ch) && (sample_data > ch_max_q[c]))
                            ? sample_data : ch_max_q[c];
            end
            if (cnt_inc_s == WIN_L) begin
              state_d    = ST_SCAN;
              scan_idx_d = '0;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end

        ST_SCAN: begin
          // Channel 0 seeds the search; later channels win only when strictly greater.
          if ((scan_idx_q == '0) || (scan_val_s > best_val_q)) begin
            best_val_d = scan_val_s;
            best_ch_d  = scan_idx_q;
          end else begin
            best_val_d = best_val_q;
            best_ch_d  = best_ch_q;
          end
          if (scan_idx_q == LAST_IDX) begin
            state_d    = ST_REPORT;
            scan_idx_d = '0;
          end else begin
            state_d    = ST_SCAN;
            scan_idx_d = scan_idx_q + CW'(1);
          end
        end

        ST_REPORT: begin
`ifdef PEAK_HYST_EN
          if (first_q || hyst_win_s) begin
            result_value_d = best_val_q;
            result_ch_d    = best_ch_q;
          end else begin
            result_value_d = prev_val_s;
            result_ch_d    = result_ch_q;
          end
          first_d = 1'b0;
`else
          result_value_d = best_val_q;
          result_ch_d    = best_ch_q;
`endif
          result_valid_d = 1'b1;
          cnt_d          = '0;
          for (int c = 0; c < CHANNELS; c++) begin
            ch_max_d[c] = '0;
          end
          state_d = ST_ACCUM;
        end

        default: begin
          state_d    = ST_ACCUM;
          cnt_d      = '0;
          scan_idx_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_ACCUM;
      cnt_q          <= '0;
      scan_idx_q     <= '0;
      best_val_q     <= '0;
      best_ch_q      <= '0;
      result_value_q <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      ch_err_q       <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_max_q[c] <= '0;
      end
`ifdef PEAK_HYST_EN
      first_q <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      scan_idx_q     <= scan_idx_d;
      best_val_q     <= best_val_d;
      best_ch_q      <= best_ch_d;
      result_value_q <= result_value_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      ch_err_q       <= ch_err_d;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_max_q[c] <= ch_max_d[c];
      end
`ifdef PEAK_HYST_EN
      first_q <= first_d;
`endif
    end
  end

endmodule

// File: tb/tb_multichan_peak_tracker.sv
// Directed self-checking bench for multichan_peak_tracker.
// Main instance: CHANNELS=4, WIDTH=12, WINDOW=8, HYST=16.
// A second instance with CHANNELS=5 (3-bit channel index) exercises the
// out-of-range channel path, since a 2-bit index cannot address channel 5.
module tb_multichan_peak_tracker;

  logic        CLOCK_50;
  logic        reset_n;
  logic        clear;
  logic        v4, v5;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;

  logic        ready4, rv4, err4;
  logic [11:0] val4;
  logic [1:0]  ch4;
  logic        ready5, rv5, err5;
  logic [11:0] val5;
  logic [2:0]  ch5;

  logic        sel;
  logic        rdy_m, rv_m;
  logic [11:0] val_m;
  logic [2:0]  ch_m;

  int n_cmp  = 0;
  int n_fail = 0;
  int rv_cnt = 0;
  int rv_base;

  multichan_peak_tracker #(.CHANNELS(4), .WIDTH(12), .WINDOW(8), .HYST(16)) u_dut4 (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .clear        (clear),
    .sample_valid (v4),
    .sample_ready (ready4),
    .sample_ch    (sample_ch[1:0]),
    .sample_data  (sample_data),
    .result_value (val4),
    .result_ch    (ch4),
    .result_valid (rv4),
    .ch_err       (err4)
  );

  multichan_peak_tracker #(.CHANNELS(5), .WIDTH(12), .WINDOW(8), .HYST(16)) u_dut5 (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .clear        (1'b0),
    .sample_valid (v5),
    .sample_ready (ready5),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .result_value (val5),
    .result_ch    (ch5),
    .result_valid (rv5),
    .ch_err       (err5)
  );

  assign rdy_m = sel ? ready5 : ready4;
  assign rv_m  = sel ? rv5 : rv4;
  assign val_m = sel ? val5 : val4;
  assign ch_m  = sel ? ch5 : {1'b0, ch4};

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Count result_valid pulses of the main instance.
  always @(posedge CLOCK_50) begin
    if (rv4) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit s5, input logic [2:0] c, input logic [11:0] d);
    @(negedge CLOCK_50);
    sample_ch   = c;
    sample_data = d;
    if (s5) v5 = 1'b1; else v4 = 1'b1;
    @(posedge CLOCK_50);
    #1;
    v4 = 1'b0;
    v5 = 1'b0;
  endtask

  task automatic send8(input bit s5, input logic [2:0] c[8], input logic [11:0] d[8]);
    for (int i = 0; i < 8; i++) send(s5, c[i], d[i]);
  endtask

  // Called right after the last accept edge (cycle T): checks latency and result.
  task automatic check_report(input bit s5, input logic [11:0] ev, input logic [2:0] ec);
    int nch;
    sel = s5;
    nch = s5 ? 5 : 4;
    for (int k = 1; k <= nch + 1; k++) begin
      @(negedge CLOCK_50);
      chk("ready_low", rdy_m, 1'b0);
      chk("rv_early", rv_m, 1'b0);
    end
    @(negedge CLOCK_50);
    chk("rv_pulse", rv_m, 1'b1);
    chk("result_value", val_m, ev);
    chk("result_ch", ch_m, ec);
    chk("ready_back", rdy_m, 1'b1);
    @(negedge CLOCK_50);
    chk("rv_single", rv_m, 1'b0);
    chk("value_hold", val_m, ev);
    chk("ch_hold", ch_m, ec);
    sel = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    v4          = 1'b0;
    v5          = 1'b0;
    sample_ch   = 3'd0;
    sample_data = 12'd0;
    sel         = 1'b0;

    // Reset state
    #3;
    chk("rst_ready", ready4, 1'b1);
    chk("rst_value", val4, 12'h000);
    chk("rst_ch", ch4, 2'd0);
    chk("rst_rv", rv4, 1'b0);
    chk("rst_err", err4, 1'b0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    // Basic window, ch2 peak 0xABC, latency check
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h100, 12'h200, 12'hABC, 12'h050, 12'h0AA, 12'h300, 12'h123, 12'h7FF});
    check_report(1'b0, 12'hABC, 3'd2);

    // Reset mid-window discards pre-reset samples
    send(1'b0, 3'd3, 12'hFFF);
    send(1'b0, 3'd0, 12'h010);
    @(negedge CLOCK_50);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_value", val4, 12'h000);
    chk("midrst_ch", ch4, 2'd0);
    chk("midrst_rv", rv4, 1'b0);
    chk("midrst_err", err4, 1'b0);
    chk("midrst_ready", ready4, 1'b1);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h011, 12'h022, 12'h033, 12'h044, 12'h005, 12'h006, 12'h007, 12'h008});
    check_report(1'b0, 12'h044, 3'd3);

    // Tie between ch1 and ch3 at 0x800
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h100, 12'h800, 12'h7FF, 12'h800, 12'h000, 12'h123, 12'h456, 12'h789});
`ifdef PEAK_HYST_EN
    check_report(1'b0, 12'h800, 3'd3);
`else
    check_report(1'b0, 12'h800, 3'd1);
`endif

    // Out-of-range channel on the 5-channel instance
    send(1'b1, 3'd0, 12'h100);
    send(1'b1, 3'd5, 12'hFFF);
    @(negedge CLOCK_50);
    chk("ch_err_pulse", err5, 1'b1);
    @(negedge CLOCK_50);
    chk("ch_err_once", err5, 1'b0);
    send(1'b1, 3'd1, 12'h050);
    send(1'b1, 3'd2, 12'h0FF);
    send(1'b1, 3'd3, 12'h010);
    send(1'b1, 3'd4, 12'h0F0);
    send(1'b1, 3'd0, 12'h001);
    send(1'b1, 3'd1, 12'h002);
    check_report(1'b1, 12'h100, 3'd0);

    // Clear mid-window (coinciding with an accept) then a fresh window
    rv_base = rv_cnt;
    send(1'b0, 3'd0, 12'hFFF);
    send(1'b0, 3'd1, 12'h010);
    send(1'b0, 3'd2, 12'h020);
    send(1'b0, 3'd3, 12'h030);
    send(1'b0, 3'd0, 12'h040);
    @(negedge CLOCK_50);
    clear       = 1'b1;
    v4          = 1'b1;
    sample_ch   = 3'd0;
    sample_data = 12'hFFF;
    @(posedge CLOCK_50);
    #1;
    clear = 1'b0;
    v4    = 1'b0;
    @(negedge CLOCK_50);
    chk("clear_rv", rv4, 1'b0);
    chk("clear_err", err4, 1'b0);
    chk("clear_ready", ready4, 1'b1);
    chk("clear_value_hold", val4, 12'h800);
`ifdef PEAK_HYST_EN
    chk("clear_ch_hold", ch4, 2'd3);
`else
    chk("clear_ch_hold", ch4, 2'd1);
`endif
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h001, 12'h002, 12'h003, 12'h123, 12'h004, 12'h005, 12'h006, 12'h007});
    check_report(1'b0, 12'h123, 3'd3);
    chk("clear_one_report", rv_cnt - rv_base, 32'd1);

    // Hysteresis pair: ch0=0x400, then ch0=0x400 / ch1=0x408
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h400, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000});
    check_report(1'b0, 12'h400, 3'd0);
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h400, 12'h408, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000});
`ifdef PEAK_HYST_EN
    check_report(1'b0, 12'h400, 3'd0);
`else
    check_report(1'b0, 12'h408, 3'd1);
`endif

    // All-zero window reports 0 on channel 0
    send8(1'b0, '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3},
          '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000});
    check_report(1'b0, 12'h000, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
